// File: rtl/mips_trace_pkg.sv
// Types and constants shared by the retirement trace generator, its FIFO and its interface.
package mips_trace_pkg;

  typedef enum logic [1:0] {
    ITYPE_R = 2'd0,
    ITYPE_I = 2'd1,
    ITYPE_J = 2'd2
  } instr_type_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } stage_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    instr_type_e itype;
    logic [4:0]  dest;
    logic        dest_wr;
    logic [31:0] dest_val;
  } retire_rec_t;

  localparam logic [5:0]  OPC_RTYPE    = 6'h00;
  localparam logic [5:0]  OPC_J        = 6'h02;
  localparam logic [5:0]  OPC_JAL      = 6'h03;
  localparam logic [31:0] SYSCALL_WORD = 32'h0000000c;
  localparam logic [31:0] V0_EXIT      = 32'd10;

  function automatic instr_type_e decode_type(input logic [31:0] instr);
    instr_type_e t;
    case (instr[31:26])
      OPC_RTYPE:      t = ITYPE_R;
      OPC_J, OPC_JAL: t = ITYPE_J;
      default:        t = ITYPE_I;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/retire_trace_gen_if.sv
// Retire-record stream: head of the record FIFO with a valid/ready handshake to the trace consumer.
interface retire_trace_gen_if;
  logic        rec_valid;
  logic        rec_ready;
  logic [31:0] rec_pc;
  logic [31:0] rec_instr;
  logic [1:0]  rec_type;
  logic [4:0]  rec_dest;
  logic        rec_dest_wr;
  logic [31:0] rec_dest_val;

  modport master (
    output rec_valid, rec_pc, rec_instr, rec_type, rec_dest, rec_dest_wr, rec_dest_val,
    input  rec_ready
  );

  modport slave (
    input  rec_valid, rec_pc, rec_instr, rec_type, rec_dest, rec_dest_wr, rec_dest_val,
    output rec_ready
  );
endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO of retire records; a push is accepted when full only if a pop happens in the same cycle.
// Head is read straight from the storage flops and forced to zero while empty.
module trace_fifo
  import mips_trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  retire_rec_t push_dat,
  input  logic        pop,
  output logic        head_vld,
  output retire_rec_t head_dat,
  output logic        full
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  retire_rec_t mem_q [DEPTH];
  retire_rec_t mem_d [DEPTH];
  logic        empty;
  logic        do_pop;
  logic        do_push;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_dat;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_vld = !empty;
  assign head_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
endmodule

// File: rtl/retire_trace_gen.sv
// Shadows pc/instr through ISS/EX/MEM/WB and emits one record per retiring instruction.
// Fetch to rec_valid is 5 cycles unstalled; records arriving while the FIFO is full and not draining are dropped.
module retire_trace_gen
  import mips_trace_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_valid,
  input  logic [31:0]         pc_fetch,
  input  logic [31:0]         instr_fetch,
  input  logic                stall,
  input  logic                flush,
  input  logic                reg_wr_wb,
  input  logic [4:0]          wr_addr_wb,
  input  logic [31:0]         wr_data_wb,
  input  logic [31:0]         v0_val,
  retire_trace_gen_if.master  rec_if,
  output logic                instr_retired,
  output logic [CNT_W-1:0]    retire_cnt,
  output logic                overflow,
  output logic                halt_seen
);
  stage_t           iss_q, iss_d, ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic             overflow_q, overflow_d;
  logic             halt_seen_q, halt_seen_d;
  retire_rec_t      rec;
  retire_rec_t      head;
  logic             head_vld;
  logic             fifo_full;

  // A flush also kills whatever sits in ISS, so EX receives a bubble.
  always_comb begin
    iss_d = iss_q;
    if (flush) begin
      iss_d = '0;
    end else if (!stall) begin
      iss_d = {fetch_valid, pc_fetch, instr_fetch};
    end
    ex_d  = (stall || flush) ? '0 : iss_q;
    mem_d = ex_q;
    wb_d  = mem_q;
  end

  always_comb begin
    rec          = '0;
    rec.pc       = wb_q.pc;
    rec.instr    = wb_q.instr;
    rec.itype    = decode_type(wb_q.instr);
    rec.dest_wr  = reg_wr_wb && (wr_addr_wb != 5'd0);
    if (rec.dest_wr) begin
      rec.dest     = wr_addr_wb;
      rec.dest_val = wr_data_wb;
    end
    retire_cnt_d = retire_cnt_q + CNT_W'(wb_q.valid);
    // When full the head is valid, so rec_ready alone decides whether space frees up.
    overflow_d   = overflow_q || (wb_q.valid && fifo_full && !rec_if.rec_ready);
    halt_seen_d  = halt_seen_q ||
                   (wb_q.valid && (wb_q.instr == SYSCALL_WORD) && (v0_val == V0_EXIT));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iss_q        <= '0;
      ex_q         <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
      retire_cnt_q <= '0;
      overflow_q   <= 1'b0;
      halt_seen_q  <= 1'b0;
    end else begin
      iss_q        <= iss_d;
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      wb_q         <= wb_d;
      retire_cnt_q <= retire_cnt_d;
      overflow_q   <= overflow_d;
      halt_seen_q  <= halt_seen_d;
    end
  end

  trace_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (wb_q.valid),
    .push_dat (rec),
    .pop      (rec_if.rec_ready),
    .head_vld (head_vld),
    .head_dat (head),
    .full     (fifo_full)
  );

  assign rec_if.rec_valid    = head_vld;
  assign rec_if.rec_pc       = head.pc;
  assign rec_if.rec_instr    = head.instr;
  assign rec_if.rec_type     = head.itype;
  assign rec_if.rec_dest     = head.dest;
  assign rec_if.rec_dest_wr  = head.dest_wr;
  assign rec_if.rec_dest_val = head.dest_val;

  assign instr_retired = wb_q.valid;
  assign retire_cnt    = retire_cnt_q;
  assign overflow      = overflow_q;
  assign halt_seen     = halt_seen_q;
endmodule

// File: tb/tb_retire_trace_gen.sv
// Bench for retire_trace_gen: directed scenarios plus a randomized run against a queue-based model.
module tb_retire_trace_gen;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             fetch_valid;
  logic [31:0]      pc_fetch;
  logic [31:0]      instr_fetch;
  logic             stall;
  logic             flush;
  logic             reg_wr_wb;
  logic [4:0]       wr_addr_wb;
  logic [31:0]      wr_data_wb;
  logic [31:0]      v0_val;
  logic             instr_retired;
  logic [CNT_W-1:0] retire_cnt;
  logic             overflow;
  logic             halt_seen;

  retire_trace_gen_if rec_if();

  retire_trace_gen #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_valid   (fetch_valid),
    .pc_fetch      (pc_fetch),
    .instr_fetch   (instr_fetch),
    .stall         (stall),
    .flush         (flush),
    .reg_wr_wb     (reg_wr_wb),
    .wr_addr_wb    (wr_addr_wb),
    .wr_data_wb    (wr_data_wb),
    .v0_val        (v0_val),
    .rec_if        (rec_if),
    .instr_retired (instr_retired),
    .retire_cnt    (retire_cnt),
    .overflow      (overflow),
    .halt_seen     (halt_seen)
  );

  always #5 clk = ~clk;

  // Reference model: pipeline as four slots (0=ISS .. 3=WB), record buffer as a bounded queue.
  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  t;
    logic [4:0]  d;
    logic        w;
    logic [31:0] val;
  } mrec_t;

  ent_t             m_pipe [4];
  mrec_t            mq[$];
  logic [CNT_W-1:0] m_cnt;
  logic             m_ovf;
  logic             m_halt;
  int               checks = 0;
  int               errors = 0;

  function automatic logic [1:0] exp_type(input logic [31:0] ins);
    if (ins[31:26] == 6'd0) return 2'd0;
    if (ins[31:26] == 6'd2 || ins[31:26] == 6'd3) return 2'd2;
    return 2'd1;
  endfunction

  function automatic mrec_t m_head();
    if (mq.size() != 0) return mq[0];
    return '0;
  endfunction

  function automatic mrec_t dut_head();
    return {rec_if.rec_pc, rec_if.rec_instr, rec_if.rec_type, rec_if.rec_dest,
            rec_if.rec_dest_wr, rec_if.rec_dest_val};
  endfunction

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic tick();
    ent_t  np [4];
    ent_t  bub;
    ent_t  f;
    mrec_t r;
    @(posedge clk);
    bub = '0;
    f   = {fetch_valid, pc_fetch, instr_fetch};
    if (reset) begin
      for (int i = 0; i < 4; i++) m_pipe[i] = bub;
      mq.delete();
      m_cnt  = '0;
      m_ovf  = 1'b0;
      m_halt = 1'b0;
    end else begin
      if (rec_if.rec_ready && mq.size() != 0) void'(mq.pop_front());
      if (m_pipe[3].v) begin
        r.pc    = m_pipe[3].pc;
        r.instr = m_pipe[3].instr;
        r.t     = exp_type(m_pipe[3].instr);
        r.w     = reg_wr_wb && (wr_addr_wb != 5'd0);
        r.d     = r.w ? wr_addr_wb : 5'd0;
        r.val   = r.w ? wr_data_wb : 32'd0;
        if (mq.size() < FIFO_DEPTH) mq.push_back(r);
        else m_ovf = 1'b1;
        m_cnt = m_cnt + 1;
        if (m_pipe[3].instr == 32'h0000000c && v0_val == 32'd10) m_halt = 1'b1;
      end
      np[3] = m_pipe[2];
      np[2] = m_pipe[1];
      if (flush) begin
        np[1] = bub;
        np[0] = bub;
      end else if (stall) begin
        np[1] = bub;
        np[0] = m_pipe[0];
      end else begin
        np[1] = m_pipe[0];
        np[0] = f;
      end
      m_pipe = np;
    end
    #1;
  endtask

  task automatic idle_inputs();
    fetch_valid      = 1'b0;
    pc_fetch         = '0;
    instr_fetch      = '0;
    stall            = 1'b0;
    flush            = 1'b0;
    reg_wr_wb        = 1'b0;
    wr_addr_wb       = '0;
    wr_data_wb       = '0;
    v0_val           = '0;
    rec_if.rec_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    settle();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) begin settle(); tick(); end
    reset = 1'b0;
    settle();
    checks++;
    if ({instr_retired, rec_if.rec_valid, overflow, halt_seen} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000", {instr_retired, rec_if.rec_valid, overflow, halt_seen});
    end
    checks++;
    if (retire_cnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt got=%0d exp=0", retire_cnt);
    end
    checks++;
    if (dut_head() !== '0) begin
      errors++;
      $display("FAIL reset_head got=%h exp=0", dut_head());
    end
    tick();
  endtask

  task automatic test_basic();
    do_reset();
    reg_wr_wb  = 1'b1;
    wr_addr_wb = 5'd10;
    wr_data_wb = 32'h15;
    for (int c = 0; c <= 5; c++) begin
      fetch_valid = (c == 0);
      pc_fetch    = 32'h0;
      instr_fetch = (c == 0) ? 32'h01095020 : 32'h0;
      settle();
      checks++;
      if (instr_retired !== 1'(c == 4)) begin
        errors++;
        $display("FAIL basic_pulse cyc=%0d got=%b exp=%b", c, instr_retired, (c == 4));
      end
      if (c == 5) begin
        checks++;
        if (dut_head() !== {32'h0, 32'h01095020, 2'd0, 5'd10, 1'b1, 32'h15} || rec_if.rec_valid !== 1'b1) begin
          errors++;
          $display("FAIL basic_rec got=%h vld=%b exp=%h vld=1", dut_head(), rec_if.rec_valid,
                   {32'h0, 32'h01095020, 2'd0, 5'd10, 1'b1, 32'h15});
        end
        checks++;
        if (retire_cnt !== 32'd1) begin
          errors++;
          $display("FAIL basic_cnt got=%0d exp=1", retire_cnt);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] got_pcs[$];
    logic [15:0] pulses;
    do_reset();
    rec_if.rec_ready = 1'b1;
    pulses = '0;
    for (int c = 0; c < 12; c++) begin
      fetch_valid = (c <= 3);
      pc_fetch    = (c == 0) ? 32'h0 : (c == 1) ? 32'h4 : 32'h8;
      instr_fetch = {6'h08, 26'(pc_fetch)};
      stall       = (c == 2);
      settle();
      pulses[c] = instr_retired;
      if (rec_if.rec_valid && rec_if.rec_ready) got_pcs.push_back(rec_if.rec_pc);
      tick();
    end
    checks++;
    if (pulses !== 16'h00D0) begin
      errors++;
      $display("FAIL stall_pulses got=%h exp=00d0", pulses);
    end
    checks++;
    if (got_pcs.size() != 3) begin
      errors++;
      $display("FAIL stall_count got=%0d exp=3", got_pcs.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_pcs[i] !== 32'(4 * i)) begin
          errors++;
          $display("FAIL stall_order idx=%0d got=%h exp=%h", i, got_pcs[i], 4 * i);
        end
      end
    end
  endtask

  task automatic test_flush();
    mrec_t got[$];
    logic [31:0] exp_pc [3];
    logic [1:0]  exp_t  [3];
    exp_pc = '{32'h0, 32'h4, 32'h40};
    exp_t  = '{2'd0, 2'd2, 2'd0};
    do_reset();
    rec_if.rec_ready = 1'b1;
    reg_wr_wb  = 1'b1;
    wr_addr_wb = 5'd3;
    for (int c = 0; c < 12; c++) begin
      wr_data_wb  = $urandom;
      fetch_valid = (c <= 4);
      pc_fetch    = (c == 4) ? 32'h40 : 32'(4 * c);
      instr_fetch = (c == 1) ? 32'h08000010 : 32'h01095020;
      flush       = (c == 3);
      settle();
      if (rec_if.rec_valid && rec_if.rec_ready) got.push_back(dut_head());
      tick();
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL flush_count got=%0d exp=3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i].pc !== exp_pc[i] || got[i].t !== exp_t[i]) begin
          errors++;
          $display("FAIL flush_rec idx=%0d got pc=%h t=%0d exp pc=%h t=%0d", i, got[i].pc, got[i].t, exp_pc[i], exp_t[i]);
        end
      end
    end
    checks++;
    if (retire_cnt !== 32'd3) begin
      errors++;
      $display("FAIL flush_cnt got=%0d exp=3", retire_cnt);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] drained[$];
    logic [31:0] exp_pc [4];
    exp_pc = '{32'h104, 32'h108, 32'h10c, 32'h114};
    do_reset();
    reg_wr_wb = 1'b1;
    for (int c = 0; c < 10; c++) begin
      fetch_valid      = (c <= 5);
      pc_fetch         = 32'h100 + 32'(4 * c);
      instr_fetch      = $urandom;
      wr_addr_wb       = 5'($urandom_range(1, 31));
      wr_data_wb       = $urandom;
      rec_if.rec_ready = (c == 9);
      settle();
      if (c == 9) begin
        checks++;
        if (overflow !== 1'b1 || rec_if.rec_pc !== 32'h100 || instr_retired !== 1'b1) begin
          errors++;
          $display("FAIL ovf_full got ovf=%b pc=%h ret=%b exp ovf=1 pc=100 ret=1", overflow, rec_if.rec_pc, instr_retired);
        end
      end
      tick();
    end
    fetch_valid      = 1'b0;
    rec_if.rec_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      settle();
      if (rec_if.rec_valid) begin
        drained.push_back(rec_if.rec_pc);
        checks++;
        if (dut_head() !== m_head()) begin
          errors++;
          $display("FAIL ovf_drain_rec got=%h exp=%h", dut_head(), m_head());
        end
      end
      tick();
    end
    checks++;
    if (drained.size() != 4) begin
      errors++;
      $display("FAIL ovf_occupancy got=%0d exp=4", drained.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (drained[i] !== exp_pc[i]) begin
          errors++;
          $display("FAIL ovf_order idx=%0d got=%h exp=%h", i, drained[i], exp_pc[i]);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky got=%b exp=1", overflow);
    end
  endtask

  task automatic test_halt();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      v0_val = (pass == 0) ? 32'd10 : 32'd4;
      for (int c = 0; c <= 5; c++) begin
        fetch_valid = (c == 0);
        pc_fetch    = 32'h20;
        instr_fetch = 32'h0000000c;
        settle();
        if (c == 5) begin
          checks++;
          if (halt_seen !== 1'(pass == 0)) begin
            errors++;
            $display("FAIL halt_flag v0=%0d got=%b exp=%b", v0_val, halt_seen, (pass == 0));
          end
          checks++;
          if (rec_if.rec_valid !== 1'b1 || rec_if.rec_instr !== 32'h0000000c || rec_if.rec_pc !== 32'h20) begin
            errors++;
            $display("FAIL halt_rec got vld=%b instr=%h pc=%h exp vld=1 instr=0000000c pc=20",
                     rec_if.rec_valid, rec_if.rec_instr, rec_if.rec_pc);
          end
        end
        tick();
      end
    end
  endtask

  task automatic test_midstream_reset();
    int pulses;
    do_reset();
    reg_wr_wb  = 1'b1;
    wr_addr_wb = 5'd7;
    wr_data_wb = 32'hABCD;
    for (int c = 0; c < 7; c++) begin
      fetch_valid = (c <= 4);
      pc_fetch    = 32'(4 * c);
      instr_fetch = 32'h01095020;
      reset       = (c == 6);
      settle();
      if (c == 6) begin
        checks++;
        if (rec_if.rec_valid !== 1'b1 || retire_cnt !== 32'd2) begin
          errors++;
          $display("FAIL mid_pre got vld=%b cnt=%0d exp vld=1 cnt=2", rec_if.rec_valid, retire_cnt);
        end
      end
      tick();
    end
    reset       = 1'b0;
    fetch_valid = 1'b0;
    settle();
    checks++;
    if ({rec_if.rec_valid, overflow, halt_seen, instr_retired} !== 4'b0000 || retire_cnt !== '0) begin
      errors++;
      $display("FAIL mid_clear got vld=%b ovf=%b halt=%b ret=%b cnt=%0d exp all 0",
               rec_if.rec_valid, overflow, halt_seen, instr_retired, retire_cnt);
    end
    tick();
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      settle();
      if (instr_retired) pulses++;
      tick();
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL mid_no_pulse got=%0d exp=0", pulses);
    end
    for (int c = 0; c <= 5; c++) begin
      fetch_valid = (c == 0);
      pc_fetch    = 32'h80;
      settle();
      if (c == 4 || c == 5) begin
        checks++;
        if (instr_retired !== 1'(c == 4) || retire_cnt !== 32'(c - 4)) begin
          errors++;
          $display("FAIL mid_fresh cyc=%0d got ret=%b cnt=%0d exp ret=%b cnt=%0d",
                   c, instr_retired, retire_cnt, (c == 4), c - 4);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset       = ($urandom_range(0, 99) == 0);
      fetch_valid = ($urandom_range(0, 3) != 0);
      pc_fetch    = $urandom;
      case ($urandom_range(0, 4))
        0:       instr_fetch = {6'h00, 26'($urandom)};
        1:       instr_fetch = {6'h02, 26'($urandom)};
        2:       instr_fetch = {6'h03, 26'($urandom)};
        3:       instr_fetch = 32'h0000000c;
        default: instr_fetch = $urandom;
      endcase
      stall            = ($urandom_range(0, 6) == 0);
      flush            = ($urandom_range(0, 9) == 0);
      reg_wr_wb        = 1'($urandom_range(0, 1));
      wr_addr_wb       = 5'($urandom_range(0, 31));
      wr_data_wb       = $urandom;
      v0_val           = ($urandom_range(0, 1) != 0) ? 32'd10 : $urandom;
      rec_if.rec_ready = ($urandom_range(0, 2) != 0);
      settle();
      checks++;
      if (instr_retired !== m_pipe[3].v) begin
        errors++;
        $display("FAIL rand_pulse cyc=%0d got=%b exp=%b", c, instr_retired, m_pipe[3].v);
      end
      checks++;
      if (rec_if.rec_valid !== (mq.size() != 0) || dut_head() !== m_head()) begin
        errors++;
        $display("FAIL rand_head cyc=%0d got vld=%b %h exp vld=%b %h", c, rec_if.rec_valid, dut_head(),
                 (mq.size() != 0), m_head());
      end
      checks++;
      if (retire_cnt !== m_cnt || overflow !== m_ovf || halt_seen !== m_halt) begin
        errors++;
        $display("FAIL rand_status cyc=%0d got cnt=%0d ovf=%b halt=%b exp cnt=%0d ovf=%b halt=%b",
                 c, retire_cnt, overflow, halt_seen, m_cnt, m_ovf, m_halt);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation time limit");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_overflow();
    test_halt();
    test_midstream_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
